// File: rtl/hps_gpio_in_cond.sv
// Input conditioner for slow external pins: two-flop synchronizer, per-bit debounce,
// edge capture with maskable interrupt, and a small Avalon-MM register window.
module hps_gpio_in_cond #(
  parameter int WIDTH           = 32,
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] pin_in,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] data_out,
  output logic             irq
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    ADDR_STATE   = 2'd0,
    ADDR_IRQMASK = 2'd1,
    ADDR_EDGECAP = 2'd2,
    ADDR_RSVD    = 2'd3
  } reg_addr_t;

  logic [WIDTH-1:0] sync1, sync2;
  logic [WIDTH-1:0] q, q_next, q_change;
  logic [CNT_W-1:0] cnt      [WIDTH];
  logic [CNT_W-1:0] cnt_next [WIDTH];
  logic [WIDTH-1:0] irqmask, edgecap, edgecap_next;
  logic [31:0]      rd_mux;
  logic             wr_en;

  assign wr_en = chipselect && !write_n;

  // NOTE: every variable assigned in always_comb gets a default first, so no path leaves it
  // holding its old value (which would infer a latch).
  always_comb begin
    q_next = q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_next[i] = '0;
      if (sync2[i] != q[i]) begin
        if (cnt[i] == CNT_MAX) q_next[i] = sync2[i];
        else                   cnt_next[i] = cnt[i] + CNT_W'(1);
      end
    end
  end

  assign q_change = q_next ^ q;

  // A capture on the same edge as a write-1-to-clear must survive, so the set is ORed last.
  always_comb begin
    edgecap_next = edgecap;
    if (wr_en && reg_addr_t'(address) == ADDR_EDGECAP)
      edgecap_next = edgecap & ~writedata[WIDTH-1:0];
    edgecap_next = edgecap_next | q_change;
  end

  always_comb begin
    rd_mux = '0;
    case (reg_addr_t'(address))
      ADDR_STATE:   rd_mux[WIDTH-1:0] = q;
      ADDR_IRQMASK: rd_mux[WIDTH-1:0] = irqmask;
      ADDR_EDGECAP: rd_mux[WIDTH-1:0] = edgecap;
      default:      rd_mux = '0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values;
  // the per-bit counters are plain flops (not a RAM), so resetting the whole array is legitimate.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1    <= '0;
      sync2    <= '0;
      q        <= '0;
      irqmask  <= '0;
      edgecap  <= '0;
      readdata <= '0;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      sync1    <= pin_in;
      sync2    <= sync1;
      q        <= q_next;
      edgecap  <= edgecap_next;
      readdata <= rd_mux;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= cnt_next[i];
      if (wr_en && reg_addr_t'(address) == ADDR_IRQMASK)
        irqmask <= writedata[WIDTH-1:0];
    end
  end

  assign data_out = q;
  assign irq      = |(edgecap & irqmask);

endmodule

// File: tb/tb_hps_gpio_in_cond.sv
// Self-checking bench for hps_gpio_in_cond (WIDTH=32, DEBOUNCE_CYCLES=4): directed scenarios
// followed by random pins and bus traffic, all compared against a window-based reference model.
module tb_hps_gpio_in_cond;

  localparam int W = 32;
  localparam int D = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [W-1:0]  pin_in;
  logic [1:0]    address;
  logic          chipselect;
  logic          write_n;
  logic [31:0]   writedata;
  logic [31:0]   readdata;
  logic [W-1:0]  data_out;
  logic          irq;

  int tests = 0;
  int fails = 0;

  // Reference model state
  logic [W-1:0] m_q, m_mask, m_ecap;
  logic [31:0]  m_rd;
  logic [W-1:0] samples[$];   // pin_in as sampled at each edge since reset

  hps_gpio_in_cond #(.WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .reset_n(reset_n), .pin_in(pin_in), .address(address),
    .chipselect(chipselect), .write_n(write_n), .writedata(writedata),
    .readdata(readdata), .data_out(data_out), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q = '0; m_mask = '0; m_ecap = '0; m_rd = '0;
    samples.delete();
    for (int j = 0; j < D + 2; j++) samples.push_back('0);
  endtask

  // A stable bit flips once the synchronized value (pin delayed two edges) has disagreed
  // with it for D consecutive edges.
  task automatic model_edge();
    logic [W-1:0] change;
    int n;
    if (!reset_n) begin
      model_reset();
      return;
    end
    n = samples.size();
    change = '0;
    for (int i = 0; i < W; i++) begin
      bit all_diff = 1'b1;
      for (int j = 0; j < D; j++)
        if (samples[n-2-j][i] == m_q[i]) all_diff = 1'b0;
      change[i] = all_diff;
    end
    case (address)
      2'd0: m_rd = m_q;
      2'd1: m_rd = m_mask;
      2'd2: m_rd = m_ecap;
      default: m_rd = '0;
    endcase
    if (chipselect && !write_n) begin
      if (address == 2'd1) m_mask = writedata;
      if (address == 2'd2) m_ecap = m_ecap & ~writedata;
    end
    m_ecap = m_ecap | change;
    m_q    = m_q ^ change;
    samples.push_back(pin_in);
    void'(samples.pop_front());
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("data_out", data_out, m_q);
    check("irq", {31'b0, irq}, {31'b0, |(m_ecap & m_mask)});
    check("readdata", readdata, m_rd);
  endtask

  task automatic bus(input logic cs, input logic wn, input logic [1:0] a, input logic [31:0] wd);
    chipselect = cs; write_n = wn; address = a; writedata = wd;
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    pin_in = '0;
    bus(1'b0, 1'b1, 2'd0, '0);
    reset_n = 1'b0;
    model_reset();
    #3;
    check("reset_data_out", data_out, 32'h0);
    check("reset_irq", {31'b0, irq}, 32'h0);
    check("reset_readdata", readdata, 32'h0);
    steps(2);
    reset_n = 1'b1;
    steps(8);

    // Latency: pin 0 rises, flips on the sixth edge (k+5)
    pin_in[0] = 1'b1;
    steps(5);
    check("latency_before", data_out, 32'h0);
    bus(1'b0, 1'b1, 2'd2, '0);
    step();
    check("latency_at_k5", data_out, 32'h1);
    step();
    check("latency_edgecap_read", readdata, 32'h1);

    // Clear all captures, then a 3-cycle glitch on pin 3 must be rejected
    bus(1'b1, 1'b0, 2'd2, 32'hFFFF_FFFF);
    step();
    bus(1'b0, 1'b1, 2'd2, '0);
    pin_in[3] = 1'b1;
    steps(3);
    pin_in[3] = 1'b0;
    steps(8);
    check("glitch_data_out", data_out, 32'h1);
    check("glitch_edgecap", readdata, 32'h0);
    check("glitch_irq", {31'b0, irq}, 32'h0);

    // Interrupt: unmask bit 0, drop pin 0, then acknowledge
    bus(1'b1, 1'b0, 2'd1, 32'h1);
    step();
    bus(1'b0, 1'b1, 2'd1, '0);
    pin_in[0] = 1'b0;
    steps(7);
    check("irq_asserted", {31'b0, irq}, 32'h1);
    bus(1'b1, 1'b0, 2'd2, 32'h1);
    step();
    check("irq_cleared", {31'b0, irq}, 32'h0);
    bus(1'b0, 1'b1, 2'd2, '0);
    steps(2);
    check("irq_ack_read", readdata, 32'h0);

    // Collision: clear of bit 5 lands on the edge where q[5] flips
    pin_in[5] = 1'b1;
    steps(5);
    bus(1'b1, 1'b0, 2'd2, 32'h20);
    step();
    check("collision_q5", data_out, 32'h20);
    bus(1'b0, 1'b1, 2'd2, '0);
    steps(2);
    check("collision_edgecap5", readdata & 32'h20, 32'h20);

    // Bus: address 0 is read-only, address 3 reads zero
    bus(1'b1, 1'b0, 2'd0, 32'hDEAD_BEEF);
    step();
    bus(1'b0, 1'b1, 2'd0, '0);
    step();
    check("bus_addr0", readdata, 32'h20);
    bus(1'b1, 1'b0, 2'd3, 32'hDEAD_BEEF);
    step();
    bus(1'b0, 1'b1, 2'd3, '0);
    step();
    check("bus_addr3", readdata, 32'h0);

    // Mid-count reset: all pins high, reset when counters hold 2
    pin_in = '1;
    steps(4);
    reset_n = 1'b0;
    model_reset();
    #2;
    check("midreset_data_out", data_out, 32'h0);
    check("midreset_irq", {31'b0, irq}, 32'h0);
    check("midreset_readdata", readdata, 32'h0);
    steps(2);
    reset_n = 1'b1;
    steps(5);
    check("release_edge5", data_out, 32'h0);
    step();
    check("release_edge6", data_out, 32'hFFFF_FFFF);

    // Random pins (sparse flips so both glitches and settled levels occur) and bus traffic
    for (int t = 0; t < 600; t++) begin
      if ($urandom_range(0, 3) == 0) pin_in = pin_in ^ ($urandom & $urandom & $urandom);
      bus($urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
          ($urandom_range(0, 1) == 1) ? $urandom : 32'hFFFF_FFFF);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/hps_gpio_in_cond.md
HPS_GPIO_IN_COND -- requirements
Module: hps_gpio_in_cond

Interface
REQ-001 Parameter WIDTH, default 32, number of conditioned input bits; the block SHALL support 1..32.
REQ-002 Parameter DEBOUNCE_CYCLES, default 1000, consecutive cycles a synchronized bit must differ from its stable state before the stable state is updated; the block SHALL support values of 1 or more.
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL be clocked on its rising edge.
REQ-004 Port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 Port pin_in, input, WIDTH bits: raw asynchronous inputs such as endstops and switches.
REQ-006 Port address, input, 2 bits: Avalon-MM word address.
REQ-007 Port chipselect, input, 1 bit: Avalon-MM select.
REQ-008 Port write_n, input, 1 bit: Avalon-MM write strobe, active-low.
REQ-009 Port writedata, input, 32 bits: Avalon-MM write data.
REQ-010 Port readdata, output, 32 bits: Avalon-MM read data, registered.
REQ-011 Port data_out, output, WIDTH bits: debounced stable state; it drives the downstream PIO in_port.
REQ-012 Port irq, output, 1 bit: interrupt request, active-high.

Function
REQ-013 Each pin_in bit SHALL pass through a two-flop synchronizer (sync1 then sync2); only sync2 feeds the later logic.
REQ-014 Each bit SHALL have a stable flop q[i] and a counter cnt[i] of width clog2(DEBOUNCE_CYCLES) (minimum 1 bit).
REQ-015 When sync2[i] equals q[i], cnt[i] SHALL be cleared to 0 on the next edge.
REQ-016 When sync2[i] differs from q[i] and cnt[i] is below DEBOUNCE_CYCLES-1, cnt[i] SHALL increment by 1.
REQ-017 When sync2[i] differs from q[i] and cnt[i] equals DEBOUNCE_CYCLES-1, q[i] SHALL take sync2[i] and cnt[i] SHALL clear to 0 on the same edge.
REQ-018 Latency: for a level first sampled at edge k and held, q SHALL change at edge k+1+DEBOUNCE_CYCLES.
REQ-019 Glitch rejection: a difference lasting fewer than DEBOUNCE_CYCLES sync2 cycles SHALL leave q unchanged and SHALL restart the count from 0.
REQ-020 data_out SHALL equal q, with no extra register stage.
REQ-021 Edge capture: when q[i] changes (either direction), edgecap[i] SHALL be set to 1 on the same edge that q[i] updates.
REQ-022 Register map, word addressed:
  - Address 0: q, read-only; writes are ignored.
  - Address 1: irqmask[WIDTH-1:0], read/write.
  - Address 2: edgecap, read; a write clears each bit where writedata is 1 (write-1-to-clear).
  - Address 3: reads 0; writes are ignored.
REQ-023 A write SHALL take effect on the edge where chipselect=1 and write_n=0.
REQ-024 If an edge sets edgecap[i] on the same edge that a write-1-to-clear targets bit i, the set SHALL win and the bit SHALL read 1.
REQ-025 readdata SHALL update every cycle to the address-0..3 mux value, zero-extended to 32 bits, regardless of chipselect; read latency is 1 cycle.
REQ-026 irq SHALL equal the OR of (edgecap AND irqmask), decoded combinationally from registers with no extra delay.
REQ-027 Unused writedata bits at and above WIDTH SHALL be ignored, and those bits SHALL read as 0.

Reset
REQ-028 While reset_n=0, all of the following SHALL be 0 asynchronously: sync1, sync2, q, cnt, irqmask, edgecap and readdata. data_out and irq are therefore 0.
REQ-029 Deassertion of reset_n SHALL leave the bus responsive from the first following edge; a pin held at 1 through reset SHALL appear on data_out after DEBOUNCE_CYCLES+2 edges.
REQ-030 Reset asserted mid-count SHALL discard the count; counting restarts from 0 after release.

Verification (all scenarios use DEBOUNCE_CYCLES=4 and WIDTH=32)
REQ-031 Latency: pin_in[0] rises 0 to 1 before edge k and is held. Required: data_out[0]=1 from edge k+5, edgecap[0]=1 at the same edge, and a read of address 2 returns 0x00000001 one cycle after it is issued.
REQ-032 Glitch: pin_in[3] is pulsed high for 3 cycles, then low. Required: data_out stays 0x00000000, edgecap stays 0 and irq stays 0.
REQ-033 Interrupt: write irqmask=0x00000001, then toggle pin 0 as in REQ-031. Required: irq=1. Write 0x00000001 to address 2. Required: irq=0 and address 2 reads 0.
REQ-034 Set/clear collision: arrange a write-1-to-clear of bit 5 on the exact edge q[5] changes. Required: edgecap[5]=1 afterwards.
REQ-035 Mid-count reset: pin_in is set to 0xFFFFFFFF and reset_n is pulsed low at cnt=2. Required: all outputs 0 during reset, and data_out=0xFFFFFFFF exactly 6 edges after release.
REQ-036 Bus: write 0xDEADBEEF to address 0, then read addresses 0 and 3. Required: address 0 returns q (unchanged by the write) and address 3 returns 0x00000000.
